// File: rtl/mix_pair_sequencer.sv
// mix_pair_sequencer: Threefish-1024 MIX stage, one word pair per cycle.
// Drives word_o to the external x0/x1 selectors, applies MIX to the returned
// pair and assembles the 1024-bit result for the permute stage.
// Build option: MIX_INPUT_REG_EN registers x0_i/x1_i before MIX. This adds
// one RUN cycle. Ports and results are the same in both builds.
//
//  state | meaning
//  IDLE  | waiting for start_i, word_o held at 0
//  RUN   | presenting word indices and writing MIX results
//  DONE  | one-cycle done_o pulse, result complete
module mix_pair_sequencer #(
   parameter int WORD_W    = 64,
   parameter int NUM_PAIRS = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start_i,
   input  logic [2:0]                      round_i,
   output logic [3:0]                      word_o,
   input  logic [WORD_W-1:0]               x0_i,
   input  logic [WORD_W-1:0]               x1_i,
   output logic                            busy_o,
   output logic                            done_o,
   output logic [2*NUM_PAIRS*WORD_W-1:0]   mix_state_o
);

   localparam int MW = 2 * NUM_PAIRS * WORD_W;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   // Rotation constants, row = round mod 8, column = pair index
   localparam logic [5:0] ROT [8][8] = '{
      '{6'd24, 6'd13, 6'd8,  6'd47, 6'd8,  6'd17, 6'd22, 6'd37},
      '{6'd38, 6'd19, 6'd10, 6'd55, 6'd49, 6'd18, 6'd23, 6'd52},
      '{6'd33, 6'd4,  6'd51, 6'd13, 6'd34, 6'd41, 6'd59, 6'd17},
      '{6'd5,  6'd20, 6'd48, 6'd41, 6'd47, 6'd28, 6'd16, 6'd25},
      '{6'd41, 6'd9,  6'd37, 6'd31, 6'd12, 6'd47, 6'd44, 6'd30},
      '{6'd16, 6'd34, 6'd56, 6'd51, 6'd4,  6'd53, 6'd42, 6'd41},
      '{6'd31, 6'd44, 6'd47, 6'd46, 6'd19, 6'd42, 6'd44, 6'd25},
      '{6'd9,  6'd48, 6'd35, 6'd52, 6'd23, 6'd31, 6'd37, 6'd20}
   };

   state_t          state_q, state_d;
   logic [3:0]      cyc_q, cyc_d;
   logic [2:0]      round_q, round_d;
   logic [3:0]      word_q, word_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [MW-1:0]   mix_q, mix_d;

   logic            wr_en;
   logic [2:0]      wr_pair;
   logic [63:0]     a0, a1, y0, y1;
   logic [127:0]    rot_w;
   logic [5:0]      rot;

`ifdef MIX_INPUT_REG_EN
   localparam logic [3:0] LAST_CYC = 4'd8;
   logic [63:0]     x0_q, x0_d, x1_q, x1_d;
`else
   localparam logic [3:0] LAST_CYC = 4'd7;
`endif

   // MIX datapath: operand source and target pair depend on the build
   always_comb begin
`ifdef MIX_INPUT_REG_EN
      a0      = x0_q;
      a1      = x1_q;
      wr_en   = (state_q == ST_RUN) && (cyc_q != 4'd0);
      wr_pair = cyc_q[2:0] - 3'd1;
`else
      a0      = x0_i;
      a1      = x1_i;
      wr_en   = (state_q == ST_RUN);
      wr_pair = cyc_q[2:0];
`endif
      rot   = ROT[round_q][wr_pair];
      y0    = a0 + a1;
      rot_w = {a1, a1} << rot;
      y1    = rot_w[127:64] ^ y0;
   end

   // Next-state and next-output logic
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      round_d = round_q;
      word_d  = 4'd0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      mix_d   = mix_q;
`ifdef MIX_INPUT_REG_EN
      x0_d    = x0_q;
      x1_d    = x1_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_RUN;
               round_d = round_i;
               cyc_d   = 4'd0;
               busy_d  = 1'b1;
            end
         end
         ST_RUN: begin
`ifdef MIX_INPUT_REG_EN
            if (cyc_q < 4'd8) begin
               x0_d = x0_i;
               x1_d = x1_i;
            end
`endif
            if (wr_en) begin
               mix_d[{wr_pair, 7'd0} +: 64]       = y0;
               mix_d[{wr_pair, 1'b1, 6'd0} +: 64] = y1;
            end
            if (cyc_q == LAST_CYC) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               cyc_d   = 4'd0;
            end else begin
               busy_d = 1'b1;
               cyc_d  = cyc_q + 4'd1;
               if (cyc_q < 4'd7) word_d = {cyc_q[2:0] + 3'd1, 1'b0};
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers, synchronous reset wins over everything
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cyc_q   <= 4'd0;
         round_q <= 3'd0;
         word_q  <= 4'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         mix_q   <= '0;
`ifdef MIX_INPUT_REG_EN
         x0_q    <= 64'd0;
         x1_q    <= 64'd0;
`endif
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         round_q <= round_d;
         word_q  <= word_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         mix_q   <= mix_d;
`ifdef MIX_INPUT_REG_EN
         x0_q    <= x0_d;
         x1_q    <= x1_d;
`endif
      end
   end

   assign word_o      = word_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign mix_state_o = mix_q;

endmodule
